mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the core's data bus, next to dmem. Consumes the same

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds an even-parity state between DATA and STOP.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic [2:0] OFF_TXDATA = 3'h0;
  localparam logic [2:0] OFF_STATUS = 3'h4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on rdata while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; it is only read once count says the entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, STATUS/ovf, baud counter and TX FSM.
// Define UART_TX_PARITY_EN to append an even-parity bit after the eight data bits.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam int              CNTW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  tx_state_t       state;
  logic [CW-1:0]   baud;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic            ovf;
  logic            busy;
  logic            pop;
  logic            push_ok;
  logic            wr_data;
  logic            wr_status;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] fifo_count;
  logic [7:0]      fifo_head;
  logic [31:0]     status;
  logic            unused_bits;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  // addr[1:0] and the upper store-data bits carry no meaning for this block.
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign hit       = addr[31:3] == BASE_ADDR[31:3];
  assign wr_data   = hit && we && ({addr[2], 2'b00} == OFF_TXDATA);
  assign wr_status = hit && we && ({addr[2], 2'b00} == OFF_STATUS);
  assign busy      = state != IDLE;
  assign pop       = (state == IDLE) && !empty;
  assign push_ok   = (fifo_count < DEPTH_CNT) || pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // NOTE: every bit gets a default before the field writes, so no latch can be inferred.
  always_comb begin
    status         = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
  end

  assign rdata = hit ? status : '0;

  // A dropped byte and a clear in the same cycle leave ovf set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wr_data && !push_ok) begin
      ovf <= 1'b1;
    end else if (wr_status && wdata[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  // NOTE: state and tx are registered together with non-blocking assignments, so tx
  // changes on the same edge the state advances and never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift      <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_head;
`endif
            baud       <= BAUD_LAST;
            bit_idx    <= '0;
            tx         <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            baud  <= BAUD_LAST;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_LAST;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud == '0) begin
            baud  <= BAUD_LAST;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud == '0) begin
            baud  <= BAUD_LAST;
            state <= IDLE;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model compared every cycle, plus literal vectors.
// Honors UART_TX_PARITY_EN the same way the design does.
module tb_mmio_uart_tx;

  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
`else
  localparam int          NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;

  int tests = 0;
  int fails = 0;
  int busy_samples = 0;

  // Reference model: queue of accepted bytes plus the frame currently on the line.
  logic [7:0]  q[$];
  int          left = 0;
  int          pos  = 0;
  logic [10:0] frame = '1;
  logic        ovf_m = 1'b0;
  bit          valid = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .hit   (hit),
    .rdata (rdata),
    .tx    (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit k of the result is what the line carries during the k-th bit time.
  function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  function automatic logic [31:0] exp_status();
    return {28'd0, ovf_m, left != 0, q.size() == 0, q.size() == DEPTH};
  endfunction

  task automatic model_step();
    logic       idle;
    logic       wr;
    logic       set_ovf;
    logic [7:0] b;
    if (rst) begin
      q.delete();
      left  = 0;
      pos   = 0;
      ovf_m = 1'b0;
      valid = 1'b1;
      return;
    end
    idle = (left == 0);
    if (!idle) begin
      left--;
      pos++;
    end
    if (idle && q.size() != 0) begin
      b     = q.pop_front();
      frame = make_frame(b);
      left  = NBITS * DIV;
      pos   = 0;
    end
    wr      = (addr[31:3] == BASE[31:3]) && we;
    set_ovf = 1'b0;
    if (wr && !addr[2]) begin
      if (q.size() < DEPTH) q.push_back(wdata[7:0]);
      else set_ovf = 1'b1;
    end
    if (set_ovf) ovf_m = 1'b1;
    else if (wr && addr[2] && wdata[3]) ovf_m = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; the store is sampled on the next edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = BASE + 32'h4;
    wdata = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(left == 0 && q.size() == 0) && n < 3000) begin
      step(1);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  logic tv [64];
  logic bv [64];
  int   seq [11];
  int   nbusy;
  int   snap;
  logic [7:0] frame_byte;

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    addr  = BASE + 32'h4;
    wdata = '0;

    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (valid) begin
          check("tx", {31'd0, tx}, {31'd0, (left != 0) ? frame[pos / DIV] : 1'b1});
          check("hit", {31'd0, hit}, {31'd0, addr[31:3] == BASE[31:3]});
          check("rdata", rdata, (addr[31:3] == BASE[31:3]) ? exp_status() : 32'd0);
          if (hit && rdata[2]) busy_samples++;
        end
      end
    join_none

    // Reset and decode.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_tx", {31'd0, tx}, 32'd1);
    check("t1_status", rdata, 32'h2);
    check("t1_hit", {31'd0, hit}, 32'd1);
    step(1);
    addr = 32'h2000;
    @(negedge clk);
    check("t1_miss_hit", {31'd0, hit}, 32'd0);
    check("t1_miss_rdata", rdata, 32'd0);
    step(1);
    addr = BASE + 32'h4;

    // Single frame, literal waveform.
`ifdef UART_TX_PARITY_EN
    frame_byte = 8'h07;
    seq = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
`else
    frame_byte = 8'hA5;
    seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    store(BASE, {24'd0, frame_byte});
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      tv[j] = tx;
      bv[j] = rdata[2];
    end
    check("t2_pre_tx", {31'd0, tv[0]}, 32'd1);
    check("t2_pre_busy", {31'd0, bv[0]}, 32'd0);
    for (int b = 0; b < NBITS; b++) begin
      check($sformatf("t2_bit%0d", b),
            {28'd0, tv[1+4*b], tv[2+4*b], tv[3+4*b], tv[4+4*b]},
            (seq[b] != 0) ? 32'hF : 32'h0);
    end
    nbusy = 0;
    for (int j = 0; j < 50; j++) if (bv[j]) nbusy++;
`ifdef UART_TX_PARITY_EN
    check("t6_busy_len", nbusy, 44);
`else
    check("t2_busy_len", nbusy, 40);
`endif
    check("t2_after_tx", {31'd0, tv[1+NBITS*DIV]}, 32'd1);
    step(1);

    // Five back-to-back stores: one in flight, four queued, no overflow.
    snap = busy_samples;
    for (int i = 0; i < 5; i++) store(BASE, 32'h11 + i);
    @(negedge clk);
    check("t3_status_full", rdata, 32'h5);
    step(1);
    wait_drain();
    step(1);
    check("t3_busy_total", busy_samples - snap, 5 * NBITS * DIV);
    @(negedge clk);
    check("t3_status_idle", rdata, 32'h2);
    step(1);

    // Six stores: the sixth is dropped and sets ovf; a STATUS write clears it.
    snap = busy_samples;
    for (int i = 0; i < 6; i++) store(BASE, 32'h11 + i);
    @(negedge clk);
    check("t4_status_ovf", rdata, 32'hD);
    step(1);
    store(BASE + 32'h4, 32'h8);
    @(negedge clk);
    check("t4_status_clr", rdata, 32'h5);
    step(1);
    wait_drain();
    step(1);
    check("t4_busy_total", busy_samples - snap, 5 * NBITS * DIV);

    // Reset in the middle of data bit 0 of 0x5A.
    store(BASE, 32'h5A);
    step(7);
    @(negedge clk);
    check("t5_pre_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tx", {31'd0, tx}, 32'd1);
    check("t5_status", rdata, 32'h2);
    rst = 1'b0;
    step(1);
    snap = busy_samples;
    step(60);
    check("t5_no_frame", busy_samples - snap, 0);
    @(negedge clk);
    check("t5_idle_tx", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
